// File: rtl/sprite_line_fetcher.sv
// Sprite ROM line fetcher: streams one 16-word sprite row into a ping-pong line buffer
// while the renderer reads pixels from the display bank.
module sprite_line_fetcher #(
  parameter int LAT_EBR = 2,
  parameter int LAT_LUT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_sprite_i,
  input  logic [5:0]  req_row_i,
  output logic [2:0]  rom_sprite_sel_o,
  output logic [9:0]  rom_word_addr_o,
  input  logic [15:0] rom_data_i,
  input  logic        swap_i,
  input  logic [5:0]  rd_x_i,
  output logic [3:0]  rd_pix_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int PIPE_D = (LAT_LUT > LAT_EBR) ? LAT_LUT : LAT_EBR;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t      state_q;
  logic        ready_q, busy_q, done_q;
  logic        lut_q, disp_q, fill_q, pending_q;
  logic [2:0]  sel_q;
  logic [9:0]  addr_q;
  logic [3:0]  word_q;
  logic [PIPE_D-1:0] tag_v_q;
  logic [3:0]  tag_idx_q [PIPE_D];
  logic [15:0] bank_q [2][16];

  logic        swap_now, disp_d, accept;
  logic        cap_v;
  logic [3:0]  cap_idx;
  logic [15:0] disp_word;

  // A deferred swap is honoured on the first idle edge, which is the edge ending the done cycle.
  assign swap_now = (state_q == S_IDLE) && (swap_i || pending_q);
  assign disp_d   = disp_q ^ swap_now;
  assign accept   = (state_q == S_IDLE) && req_valid_i && ready_q;

  always_comb begin
    cap_v   = 1'b0;
    cap_idx = '0;
    if (state_q != S_IDLE) begin
      cap_v   = lut_q ? tag_v_q[LAT_LUT-1]   : tag_v_q[LAT_EBR-1];
      cap_idx = lut_q ? tag_idx_q[LAT_LUT-1] : tag_idx_q[LAT_EBR-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      word_q    <= '0;
      lut_q     <= 1'b0;
      disp_q    <= 1'b0;
      fill_q    <= 1'b1;
      pending_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          disp_q    <= disp_d;
          pending_q <= 1'b0;
          if (accept) begin
            sel_q   <= req_sprite_i;
            addr_q  <= {req_row_i, 4'd0};
            word_q  <= '0;
            lut_q   <= req_sprite_i[2];
            fill_q  <= ~disp_d;
            state_q <= S_ISSUE;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (swap_i) pending_q <= 1'b1;
          if (word_q == 4'd15) begin
            state_q <= S_DRAIN;
          end else begin
            word_q <= word_q + 4'd1;
            addr_q <= {addr_q[9:4], word_q + 4'd1};
          end
        end
        S_DRAIN: begin
          if (swap_i) pending_q <= 1'b1;
          if (cap_v && (cap_idx == 4'd15)) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag pipeline: stage j holds the word index whose address was driven j+1 cycles ago.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_D; i++) begin
        tag_v_q[i]   <= 1'b0;
        tag_idx_q[i] <= '0;
      end
    end else begin
      tag_v_q[0]   <= (state_q == S_ISSUE);
      tag_idx_q[0] <= word_q;
      for (int i = 1; i < PIPE_D; i++) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < 16; w++) begin
          bank_q[b][w] <= '0;
        end
      end
    end else if (cap_v) begin
      bank_q[fill_q][cap_idx] <= rom_data_i;
    end
  end

  assign disp_word = bank_q[disp_q][rd_x_i[5:2]];

  // Leftmost pixel of each word lives in the most significant nibble.
  always_comb begin
    rd_pix_o = '0;
    case (rd_x_i[1:0])
      2'd0: rd_pix_o = disp_word[15:12];
      2'd1: rd_pix_o = disp_word[11:8];
      2'd2: rd_pix_o = disp_word[7:4];
      2'd3: rd_pix_o = disp_word[3:0];
      default: rd_pix_o = '0;
    endcase
  end

  assign req_ready_o      = ready_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign rom_sprite_sel_o = sel_q;
  assign rom_word_addr_o  = addr_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Bench for sprite_line_fetcher: latency-accurate ROM model, table of fetches with a
// pixel scoreboard, plus hand sequences for deferred swap, held request and mid-fetch reset.
module tb_sprite_line_fetcher;

  logic        clk;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_sprite_i;
  logic [5:0]  req_row_i;
  logic [2:0]  rom_sprite_sel_o;
  logic [9:0]  rom_word_addr_o;
  logic [15:0] rom_data_i;
  logic        swap_i;
  logic [5:0]  rd_x_i;
  logic [3:0]  rd_pix_o;
  logic        busy_o;
  logic        done_o;

  sprite_line_fetcher #(.LAT_EBR(2), .LAT_LUT(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_sprite_i     (req_sprite_i),
    .req_row_i        (req_row_i),
    .rom_sprite_sel_o (rom_sprite_sel_o),
    .rom_word_addr_o  (rom_word_addr_o),
    .rom_data_i       (rom_data_i),
    .swap_i           (swap_i),
    .rd_x_i           (rd_x_i),
    .rd_pix_o         (rd_pix_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit rom_mode = 1'b0;
  logic [3:0] shown_pix0;
  logic [3:0] exp_pix_q [$];

  function automatic logic [15:0] rom_func(input logic [2:0] sp, input logic [9:0] a, input bit mode);
    if (sp == 3'd7) return 16'h0000;
    if (mode) return 16'h1234 + 16'(a[3:0]) * 16'h1111;
    return {sp, 3'b000, a};
  endfunction

  // ROM model: data for an address appears 2 (EBR) or 3 (LUT) cycles after it is driven.
  logic [9:0] ah [3];
  logic [2:0] sh [3];
  always @(posedge clk) begin
    ah[0] <= rom_word_addr_o;
    ah[1] <= ah[0];
    ah[2] <= ah[1];
    sh[0] <= rom_sprite_sel_o;
    sh[1] <= sh[0];
    sh[2] <= sh[1];
  end
  always_comb begin
    rom_data_i = (rom_sprite_sel_o >= 3'd4) ? rom_func(sh[2], ah[2], rom_mode)
                                            : rom_func(sh[1], ah[1], rom_mode);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_fetch(input logic [2:0] sp, input logic [5:0] rw, input int done_cyc,
                           input int swap_at, input bit hold, input bit do_read);
    logic [15:0] w;
    logic [3:0]  new_pix0;
    logic [3:0]  p;
    bit          seen;
    int          err0;
    err0     = errors;
    w        = rom_func(sp, {rw, 4'd0}, rom_mode);
    new_pix0 = w[15:12];
    rd_x_i   = 6'd0;
    @(negedge clk);
    chk("ready_before_req", req_ready_o, 1);
    req_valid_i  = 1'b1;
    req_sprite_i = sp;
    req_row_i    = rw;
    if (do_read) begin
      for (int k = 0; k < 16; k++) begin
        w = rom_func(sp, {rw, 4'(k)}, rom_mode);
        for (int n = 0; n < 4; n++) exp_pix_q.push_back(w[15-4*n -: 4]);
      end
    end
    for (int c = 1; c <= done_cyc; c++) begin
      @(negedge clk);
      if (!hold) req_valid_i = 1'b0;
      if (c <= 16) begin
        chk($sformatf("addr_c%0d", c), rom_word_addr_o, {rw, 4'(c - 1)});
        chk($sformatf("sel_c%0d", c), rom_sprite_sel_o, sp);
      end
      if (c < done_cyc) begin
        chk($sformatf("busy_c%0d", c), busy_o, 1);
        chk($sformatf("ready_c%0d", c), req_ready_o, 0);
        chk($sformatf("done_c%0d", c), done_o, 0);
      end else begin
        chk($sformatf("done_c%0d", c), done_o, 1);
        chk($sformatf("ready_done_c%0d", c), req_ready_o, 1);
        chk($sformatf("busy_done_c%0d", c), busy_o, 0);
      end
      if (swap_at > 0) chk($sformatf("disp_hold_c%0d", c), rd_pix_o, shown_pix0);
      swap_i = (c == swap_at);
    end
    @(negedge clk);
    swap_i = 1'b0;
    chk("done_one_cycle", done_o, 0);
    if (hold) begin
      chk("reaccept_busy", busy_o, 1);
      req_valid_i = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge clk);
        if (done_o) seen = 1'b1;
      end
      chk("reaccept_done", seen, 1);
    end
    if (swap_at > 0) begin
      chk("swap_deferred", rd_pix_o, new_pix0);
      swap_i = 1'b1;
      @(negedge clk);
      swap_i = 1'b0;
      chk("swap_back", rd_pix_o, shown_pix0);
    end
    if (do_read) begin
      swap_i = 1'b1;
      @(negedge clk);
      swap_i = 1'b0;
      for (int x = 0; x < 64; x++) begin
        rd_x_i = 6'(x);
        #1;
        if (exp_pix_q.size() == 0) begin
          chk($sformatf("pix_queue_x%0d", x), 1, 0);
        end else begin
          p = exp_pix_q.pop_front();
          chk($sformatf("pix_s%0d_r%0d_x%0d", sp, rw, x), rd_pix_o, p);
        end
      end
      rd_x_i = 6'd0;
      shown_pix0 = new_pix0;
    end
    $display("fetch sprite=%0d row=%0d done_cycle=%0d swap_at=%0d hold=%0d new_errors=%0d",
             sp, rw, done_cyc, swap_at, hold, errors - err0);
  endtask

  typedef struct {
    logic [2:0] sp;
    logic [5:0] row;
    int         done_cyc;
  } vec_t;

  vec_t vecs [7];
  bit   seen_done;
  bit   nonzero;

  initial begin
    vecs[0] = '{sp: 3'd2, row: 6'd5,  done_cyc: 19};
    vecs[1] = '{sp: 3'd5, row: 6'd63, done_cyc: 20};
    vecs[2] = '{sp: 3'd0, row: 6'd0,  done_cyc: 19};
    vecs[3] = '{sp: 3'd3, row: 6'd42, done_cyc: 19};
    vecs[4] = '{sp: 3'd7, row: 6'd17, done_cyc: 20};
    vecs[5] = '{sp: 3'd6, row: 6'd1,  done_cyc: 20};
    vecs[6] = '{sp: 3'd4, row: 6'd33, done_cyc: 20};

    reset        = 1'b1;
    req_valid_i  = 1'b0;
    req_sprite_i = '0;
    req_row_i    = '0;
    swap_i       = 1'b0;
    rd_x_i       = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_ready", req_ready_o, 1);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_sel", rom_sprite_sel_o, 0);
    chk("reset_addr", rom_word_addr_o, 0);
    nonzero = 1'b0;
    for (int x = 0; x < 64; x++) begin
      rd_x_i = 6'(x);
      #1;
      if (rd_pix_o != 4'd0) nonzero = 1'b1;
    end
    chk("reset_pix_zero", nonzero, 0);
    rd_x_i = 6'd0;
    shown_pix0 = 4'd0;

    for (int i = 0; i < 7; i++) begin
      run_fetch(vecs[i].sp, vecs[i].row, vecs[i].done_cyc, 0, 1'b0, 1'b1);
    end

    // Swap requested mid-fetch is deferred to the end of the done cycle.
    run_fetch(3'd1, 6'd12, 19, 8, 1'b0, 1'b1);

    // Known word 0x1234 at word 0 -> pixels 1,2,3,4.
    rom_mode = 1'b1;
    run_fetch(3'd1, 6'd0, 19, 0, 1'b0, 1'b1);
    rom_mode = 1'b0;
    for (int x = 0; x < 4; x++) begin
      rd_x_i = 6'(x);
      #1;
      chk($sformatf("pack_x%0d", x), rd_pix_o, 4'(x + 1));
    end
    rd_x_i = 6'd0;

    // Request held high for the whole fetch: one fetch, next accept only after done.
    run_fetch(3'd2, 6'd5, 19, 0, 1'b1, 1'b0);

    // Reset in cycle 10 of a fetch.
    @(negedge clk);
    req_valid_i  = 1'b1;
    req_sprite_i = 3'd3;
    req_row_i    = 6'd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      req_valid_i = 1'b0;
      if (c == 10) reset = 1'b1;
    end
    @(negedge clk);
    chk("midreset_ready", req_ready_o, 1);
    chk("midreset_busy", busy_o, 0);
    chk("midreset_done", done_o, 0);
    for (int x = 0; x < 64; x += 9) begin
      rd_x_i = 6'(x);
      #1;
      chk($sformatf("midreset_pix_x%0d", x), rd_pix_o, 0);
    end
    rd_x_i = 6'd0;
    @(negedge clk);
    reset = 1'b0;
    swap_i = 1'b1;
    seen_done = 1'b0;
    @(negedge clk);
    swap_i = 1'b0;
    nonzero = 1'b0;
    for (int x = 0; x < 64; x++) begin
      rd_x_i = 6'(x);
      #1;
      if (rd_pix_o != 4'd0) nonzero = 1'b1;
      if (done_o) seen_done = 1'b1;
    end
    chk("midreset_other_bank_zero", nonzero, 0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done_o) seen_done = 1'b1;
    end
    chk("midreset_no_done", seen_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
